// File: rtl/fetch_stage.sv
// fetch_stage: owns PCF, fetches over a req/ready handshake with one outstanding request,
// and drives the IF/ID register while absorbing stalls, flushes and Execute redirects.
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  StallF,
   input  logic                  FlushD,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] InstrD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D,
   output logic                  ValidD
);
   typedef enum logic [1:0] {S_FETCH, S_DROP, S_HOLD} state_t;
   state_t r_state, w_state_n;
   logic [DATA_WIDTH-1:0] r_pcf, r_pend, r_hold_instr, r_hold_pc;
   logic [DATA_WIDTH-1:0] r_instr, r_pcd, r_pcp4;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] w_tgt, w_pcf_n, w_pend_n, w_dlv_instr, w_dlv_pc;
   logic                  w_xfer, w_dlv, w_hold_ld;
   assign w_tgt  = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
   assign w_xfer = imem_req && imem_ready;
   assign InstrD   = r_instr;
   assign PCD      = r_pcd;
   assign PCPlus4D = r_pcp4;
   assign ValidD   = r_valid;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_state_n;

   // DROP keeps the stale request on the bus until memory answers, then jumps to the pending target
   always_comb begin
      w_state_n   = r_state;
      w_pcf_n     = r_pcf;
      w_pend_n    = r_pend;
      w_hold_ld   = 1'b0;
      w_dlv       = 1'b0;
      w_dlv_instr = r_hold_instr;
      w_dlv_pc    = r_hold_pc;
      case (r_state)
         S_FETCH:
            if (PCSrcE) begin
               if (imem_ready) w_pcf_n = w_tgt;
               else begin
                  w_pend_n  = w_tgt;
                  w_state_n = S_DROP;
               end
            end else if (w_xfer && !StallF) begin
               w_dlv       = 1'b1;
               w_dlv_instr = imem_rdata;
               w_dlv_pc    = r_pcf;
               w_pcf_n     = r_pcf + DATA_WIDTH'(4);
            end else if (w_xfer) begin
               w_hold_ld = 1'b1;
               w_state_n = S_HOLD;
            end
         S_DROP: begin
            if (PCSrcE) w_pend_n = w_tgt;
            if (imem_ready) begin
               w_pcf_n   = PCSrcE ? w_tgt : r_pend;
               w_state_n = S_FETCH;
            end
         end
         S_HOLD:
            if (PCSrcE) begin
               w_pcf_n   = w_tgt;
               w_state_n = S_FETCH;
            end else if (!StallF) begin
               w_dlv     = 1'b1;
               w_pcf_n   = r_hold_pc + DATA_WIDTH'(4);
               w_state_n = S_FETCH;
            end
         default: w_state_n = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req  = r_state != S_HOLD;
      imem_addr = r_pcf;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_pcf        <= RESET_PC;
         r_pend       <= '0;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
         r_instr      <= NOP_INSTR;
         r_pcd        <= '0;
         r_pcp4       <= '0;
         r_valid      <= 1'b0;
      end else begin
         r_pcf  <= w_pcf_n;
         r_pend <= w_pend_n;
         if (w_hold_ld) begin
            r_hold_instr <= imem_rdata;
            r_hold_pc    <= r_pcf;
         end
         if (FlushD) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
         end else if (!StallF) begin
            r_instr <= w_dlv ? w_dlv_instr : NOP_INSTR;
            r_valid <= w_dlv;
            if (w_dlv) begin
               r_pcd  <= w_dlv_pc;
               r_pcp4 <= w_dlv_pc + DATA_WIDTH'(4);
            end
         end
      end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run checked against a program-order model
// (next delivered PC is previous+4 unless redirected; IF/ID obeys flush > stall > load > bubble).
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk = 1'b0, rst_n = 1'b0, StallF = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0, imem_ready = 1'b0;
   logic [31:0] PCTargetE = '0, key = '0;
   logic        imem_req, ValidD;
   logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
   int          vectors = 0, miscompares = 0;
   logic [31:0] exp_pc, p_pcd, p_instr, p_p4, p_addr, p_tgt;
   logic        p_valid, p_stall, p_flush, p_src, p_req, p_rdy;
   int          dlv = 0, idle = 0, max_idle = 0;

   always #5 clk = ~clk;
   // memory returns a tagged copy of the address so every instruction identifies its own PC
   assign imem_rdata = imem_addr ^ key;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .StallF(StallF), .FlushD(FlushD), .PCSrcE(PCSrcE),
      .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc);
      chk({tag, "_valid"}, {31'b0, ValidD}, {31'b0, v});
      chk({tag, "_instr"}, InstrD, instr);
      chk({tag, "_pcd"}, PCD, pc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; imem_ready = 1'b1; key = '0;
      #2;
      chk_ifid("rst", 1'b0, NOP, 32'h0);
      chk("rst_p4", PCPlus4D, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'h1);
   endtask

   task automatic drive_random();
      imem_ready = $urandom_range(9) < 6;
      StallF     = $urandom_range(9) < 2;
      PCSrcE     = $urandom_range(99) < 8;
      case ($urandom_range(3))
         0:       PCTargetE = 32'hFFFF_FFF4 | 32'($urandom_range(3));
         1:       PCTargetE = 32'hFFFF_FFFC;
         default: PCTargetE = $urandom;
      endcase
      FlushD  = PCSrcE || (StallF && $urandom_range(1) == 1);
      p_stall = StallF; p_flush = FlushD; p_src = PCSrcE; p_tgt = PCTargetE;
      p_req   = imem_req; p_addr = imem_addr; p_rdy = imem_ready;
   endtask

   initial begin
      // zero-wait streaming
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         chk_ifid("stream", 1'b1, 32'(4 * i), 32'(4 * i));
         chk("stream_p4", PCPlus4D, 32'(4 * i + 4));
      end
      // two-cycle miss at 0x8
      do_reset();
      step(); step();
      imem_ready = 1'b0;
      chk("miss_addr0", imem_addr, 32'h8);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("miss_addr", imem_addr, 32'h8);
         chk_ifid("miss_bubble", 1'b0, NOP, 32'h4);
      end
      imem_ready = 1'b1;
      step();
      chk_ifid("miss_done", 1'b1, 32'h8, 32'h8);
      // stall as 0xC completes
      do_reset();
      step(); step(); step();
      StallF = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_req", {31'b0, imem_req}, 32'h0);
         chk_ifid("stall_frozen", 1'b1, 32'h8, 32'h8);
      end
      StallF = 1'b0;
      step();
      chk_ifid("stall_rel", 1'b1, 32'hC, 32'hC);
      chk("stall_next_addr", imem_addr, 32'h10);
      step();
      chk_ifid("stall_next", 1'b1, 32'h10, 32'h10);
      // redirect while 0x8 is outstanding
      do_reset();
      step(); step();
      imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h103;
      step();
      PCSrcE = 1'b0;
      chk("drop_addr0", imem_addr, 32'h8);
      chk("drop_valid0", {31'b0, ValidD}, 32'h0);
      step();
      chk("drop_addr1", imem_addr, 32'h8);
      imem_ready = 1'b1;
      step();
      chk("drop_valid2", {31'b0, ValidD}, 32'h0);
      chk("drop_new_addr", imem_addr, 32'h100);
      step();
      chk_ifid("drop_target", 1'b1, 32'h100, 32'h100);
      // flush and stall on the same edge
      do_reset();
      step(); step();
      FlushD = 1'b1; StallF = 1'b1;
      step();
      FlushD = 1'b0; StallF = 1'b0;
      chk_ifid("flush_stall", 1'b0, NOP, 32'h4);
      step();
      chk_ifid("flush_stall_pcf", 1'b1, 32'h8, 32'h8);
      // async reset in the middle of DROP
      do_reset();
      step(); step();
      imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h40; StallF = 1'b1;
      step();
      chk("mid_drop_addr", imem_addr, 32'h8);
      chk_ifid("mid_drop_held", 1'b1, 32'h4, 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk_ifid("async_rst", 1'b0, NOP, 32'h0);
      chk("async_rst_p4", PCPlus4D, 32'h0);
      chk("async_rst_addr", imem_addr, 32'h0);
      rst_n = 1'b1; PCSrcE = 1'b0; StallF = 1'b0; imem_ready = 1'b1;
      step();
      chk_ifid("restart", 1'b1, 32'h0, 32'h0);
      // PC wraps past the top of the address space
      do_reset();
      PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'hFFFF_FFFE;
      step();
      PCSrcE = 1'b0; FlushD = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      chk_ifid("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      chk("wrap_p4", PCPlus4D, 32'h0);
      step();
      chk_ifid("wrap_zero", 1'b1, 32'h0, 32'h0);
      // randomized traffic against the program-order model
      do_reset();
      key = 32'h5A5A_0000;
      exp_pc = 32'h0;
      p_pcd = PCD; p_instr = InstrD; p_p4 = PCPlus4D; p_valid = ValidD;
      drive_random();
      repeat (3000) begin
         step();
         if (p_req && !p_rdy) begin
            chk("rnd_req_held", {31'b0, imem_req}, 32'h1);
            chk("rnd_addr_stable", imem_addr, p_addr);
         end
         chk("rnd_addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
         if (p_flush) begin
            chk_ifid("rnd_flush", 1'b0, NOP, p_pcd);
            idle++;
         end else if (p_stall) begin
            chk_ifid("rnd_stall", p_valid, p_instr, p_pcd);
            chk("rnd_stall_p4", PCPlus4D, p_p4);
         end else if (ValidD) begin
            chk("rnd_seq_pc", PCD, exp_pc);
            chk("rnd_seq_instr", InstrD, exp_pc ^ key);
            chk("rnd_seq_p4", PCPlus4D, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            dlv++;
            idle = 0;
         end else begin
            chk("rnd_bubble_instr", InstrD, NOP);
            idle++;
         end
         if (p_src) exp_pc = p_tgt & ~32'd3;
         if (idle > max_idle) max_idle = idle;
         p_pcd = PCD; p_instr = InstrD; p_p4 = PCPlus4D; p_valid = ValidD;
         drive_random();
      end
      chk("rnd_progress", {31'b0, dlv > 500}, 32'h1);
      chk("rnd_max_idle", {31'b0, max_idle < 100}, 32'h1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
